// File: rtl/meter_display_regs.sv
// Display register bank: field writes land in a shadow copy and are
// transferred to the display outputs as one set on a vsync rising edge,
// so the pattern generator never shows a half-updated frame.
module meter_display_regs #(
  parameter int STALE_FRAMES = 120,
  parameter int BATT_MAX     = 100
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wr_valid,
  output logic        wr_ready,
  input  logic [2:0]  wr_addr,
  input  logic [15:0] wr_data,
  input  logic        vs,
  output logic [15:0] STATUS,
  output logic [15:0] FORCED,
  output logic [7:0]  CHARGE,
  output logic [7:0]  DISCHARGE,
  output logic [7:0]  P_SOURCED,
  output logic [7:0]  P_SINKED,
  output logic [7:0]  BATTERY,
  output logic        pending,
  output logic        stale
);

  localparam logic [15:0] STALE_MAX = 16'(STALE_FRAMES);
  localparam logic [7:0]  BATT_LIM  = 8'(BATT_MAX);
  localparam logic [2:0]  ADDR_COMMIT = 3'd7;

  typedef enum logic [1:0] {IDLE, FILL, PEND} state_t;

  state_t      state_q, state_d;
  logic        vs_q;
  logic        vs_rise;
  logic        xfer;
  logic        is_commit;
  logic        is_field;
  logic        apply;
  logic [7:0]  batt_val;
  logic [15:0] cnt_q, cnt_d;

  // Wide fields (STATUS, FORCED) and narrow fields (CHARGE..BATTERY) are kept
  // in separate arrays so no storage bit is left without a reader.
  logic [15:0] wshadow_q [0:1];
  logic [15:0] wshadow_d [0:1];
  logic [7:0]  nshadow_q [0:4];
  logic [7:0]  nshadow_d [0:4];
  logic [15:0] wdisp_q   [0:1];
  logic [15:0] wdisp_d   [0:1];
  logic [7:0]  ndisp_q   [0:4];
  logic [7:0]  ndisp_d   [0:4];

  // Ready depends on state only so the master sees a stable handshake.
  assign wr_ready  = (state_q != PEND);
  assign pending   = (state_q == PEND);
  assign stale     = (cnt_q == STALE_MAX);
  assign vs_rise   = vs & ~vs_q;
  assign xfer      = wr_valid & wr_ready;
  assign is_commit = xfer & (wr_addr == ADDR_COMMIT);
  assign is_field  = xfer & (wr_addr != ADDR_COMMIT);
  assign apply     = (state_q == PEND) & vs_rise;
  assign batt_val  = (wr_data[7:0] > BATT_LIM) ? BATT_LIM : wr_data[7:0];

  assign STATUS    = wdisp_q[0];
  assign FORCED    = wdisp_q[1];
  assign CHARGE    = ndisp_q[0];
  assign DISCHARGE = ndisp_q[1];
  assign P_SOURCED = ndisp_q[2];
  assign P_SINKED  = ndisp_q[3];
  assign BATTERY   = ndisp_q[4];

  // Next-state logic for the commit handshake.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (is_commit)     state_d = PEND;
        else if (is_field) state_d = FILL;
      end
      FILL: begin
        if (is_commit) state_d = PEND;
      end
      PEND: begin
        if (vs_rise) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Shadow writes and the atomic shadow-to-display copy.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      wshadow_d[i] = wshadow_q[i];
      wdisp_d[i]   = apply ? wshadow_q[i] : wdisp_q[i];
      if (is_field && (wr_addr == 3'(i))) wshadow_d[i] = wr_data;
    end
    for (int i = 0; i < 5; i++) begin
      nshadow_d[i] = nshadow_q[i];
      ndisp_d[i]   = apply ? nshadow_q[i] : ndisp_q[i];
      if (is_field && (wr_addr == 3'(i + 2))) begin
        nshadow_d[i] = (i == 4) ? batt_val : wr_data[7:0];
      end
    end
  end

  // Frames since last applied commit, saturating at the stale threshold.
  always_comb begin
    cnt_d = cnt_q;
    if (apply)                           cnt_d = '0;
    else if (vs_rise && cnt_q != STALE_MAX) cnt_d = cnt_q + 16'd1;
  end

  // State, edge detector and register bank.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      vs_q    <= 1'b0;
      cnt_q   <= '0;
      for (int i = 0; i < 2; i++) begin
        wshadow_q[i] <= '0;
        wdisp_q[i]   <= '0;
      end
      for (int i = 0; i < 5; i++) begin
        nshadow_q[i] <= '0;
        ndisp_q[i]   <= '0;
      end
    end else begin
      state_q <= state_d;
      vs_q    <= vs;
      cnt_q   <= cnt_d;
      for (int i = 0; i < 2; i++) begin
        wshadow_q[i] <= wshadow_d[i];
        wdisp_q[i]   <= wdisp_d[i];
      end
      for (int i = 0; i < 5; i++) begin
        nshadow_q[i] <= nshadow_d[i];
        ndisp_q[i]   <= ndisp_d[i];
      end
    end
  end

endmodule

// File: tb/tb_meter_display_regs.sv
// Directed bench for meter_display_regs with STALE_FRAMES = 3.
module tb_meter_display_regs;

  logic        clk = 1'b0;
  logic        reset;
  logic        wr_valid;
  logic        wr_ready;
  logic [2:0]  wr_addr;
  logic [15:0] wr_data;
  logic        vs;
  logic [15:0] STATUS, FORCED;
  logic [7:0]  CHARGE, DISCHARGE, P_SOURCED, P_SINKED, BATTERY;
  logic        pending, stale;

  int n_cmp = 0;
  int n_err = 0;

  meter_display_regs #(.STALE_FRAMES(3), .BATT_MAX(100)) dut (
    .clk(clk), .reset(reset),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .vs(vs),
    .STATUS(STATUS), .FORCED(FORCED), .CHARGE(CHARGE), .DISCHARGE(DISCHARGE),
    .P_SOURCED(P_SOURCED), .P_SINKED(P_SINKED), .BATTERY(BATTERY),
    .pending(pending), .stale(stale)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One bus transfer; waits a bounded time for ready.
  task automatic bus_write(input logic [2:0] a, input logic [15:0] d);
    int waited;
    waited   = 0;
    wr_valid = 1'b1;
    wr_addr  = a;
    wr_data  = d;
    while (!wr_ready && waited < 50) begin
      tick();
      waited++;
    end
    if (!wr_ready) begin
      n_cmp++; n_err++;
      $display("FAIL bus_write_timeout: wr_ready=%0b required 1", wr_ready);
    end
    tick();
    wr_valid = 1'b0;
    $display("write addr=%0d data=%h", a, d);
  endtask

  task automatic pulse_vs();
    vs = 1'b1;
    tick();
    vs = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b1; wr_valid = 1'b0; wr_addr = '0; wr_data = '0; vs = 1'b0;
    tick(); tick();
    reset = 1'b0;
    n_cmp++;
    if ({STATUS, FORCED, CHARGE, DISCHARGE, P_SOURCED, P_SINKED, BATTERY} !== 72'h0) begin
      n_err++; $display("FAIL reset_outputs: got %h required 0",
                        {STATUS, FORCED, CHARGE, DISCHARGE, P_SOURCED, P_SINKED, BATTERY});
    end
    n_cmp++;
    if ({wr_ready, pending, stale} !== 3'b100) begin
      n_err++; $display("FAIL reset_flags: ready/pend/stale=%b required 100", {wr_ready, pending, stale});
    end
    $display("reset checked");
  endtask

  task automatic test_commit();
    bus_write(3'd2, 16'h002A);
    bus_write(3'd7, 16'h0000);
    tick(); tick();
    n_cmp++;
    if (CHARGE !== 8'h00) begin
      n_err++; $display("FAIL commit_before_vs: CHARGE=%h required 00", CHARGE);
    end
    n_cmp++;
    if ({pending, wr_ready} !== 2'b10) begin
      n_err++; $display("FAIL commit_pending: pend/ready=%b required 10", {pending, wr_ready});
    end
    vs = 1'b1;
    tick();
    n_cmp++;
    if (CHARGE !== 8'h2A || pending !== 1'b0) begin
      n_err++; $display("FAIL commit_applied: CHARGE=%h pending=%b required 2a/0", CHARGE, pending);
    end
    vs = 1'b0;
    tick();
    $display("commit CHARGE=%h", CHARGE);
  endtask

  task automatic test_battery();
    logic [15:0] vals [4];
    logic [7:0]  exp  [4];
    vals[0] = 16'h00C8; exp[0] = 8'd100;
    vals[1] = 16'h0064; exp[1] = 8'd100;
    vals[2] = 16'h0063; exp[2] = 8'd99;
    vals[3] = 16'h0165; exp[3] = 8'd100;
    for (int i = 0; i < 4; i++) begin
      bus_write(3'd6, vals[i]);
      bus_write(3'd7, 16'h0000);
      pulse_vs();
      n_cmp++;
      if (BATTERY !== exp[i]) begin
        n_err++; $display("FAIL battery_clamp[%0d]: BATTERY=%0d required %0d", i, BATTERY, exp[i]);
      end
      $display("battery in=%h out=%0d", vals[i], BATTERY);
    end
    n_cmp++;
    if (CHARGE !== 8'h2A) begin
      n_err++; $display("FAIL battery_charge_kept: CHARGE=%h required 2a", CHARGE);
    end
  endtask

  task automatic test_commit_with_vs();
    bus_write(3'd2, 16'h0011);
    wr_valid = 1'b1; wr_addr = 3'd7; wr_data = '0; vs = 1'b1;
    tick();
    wr_valid = 1'b0;
    n_cmp++;
    if (CHARGE !== 8'h2A || pending !== 1'b1) begin
      n_err++; $display("FAIL sim_commit_vs: CHARGE=%h pending=%b required 2a/1", CHARGE, pending);
    end
    tick(); tick(); tick();
    n_cmp++;
    if (CHARGE !== 8'h2A) begin
      n_err++; $display("FAIL vs_held_high: CHARGE=%h required 2a", CHARGE);
    end
    vs = 1'b0;
    tick();
    vs = 1'b1;
    tick();
    n_cmp++;
    if (CHARGE !== 8'h11 || pending !== 1'b0) begin
      n_err++; $display("FAIL sim_commit_next: CHARGE=%h pending=%b required 11/0", CHARGE, pending);
    end
    vs = 1'b0;
    tick();
    $display("simultaneous commit CHARGE=%h", CHARGE);
  endtask

  task automatic test_back_to_back();
    bus_write(3'd7, 16'h0000);
    wr_valid = 1'b1; wr_addr = 3'd0; wr_data = 16'hBEEF;
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (wr_ready !== 1'b0) begin
        n_err++; $display("FAIL pend_ready[%0d]: wr_ready=%b required 0", i, wr_ready);
      end
      tick();
    end
    vs = 1'b1;
    tick();
    n_cmp++;
    if (STATUS !== 16'h0000 || wr_ready !== 1'b1) begin
      n_err++; $display("FAIL pend_exit: STATUS=%h ready=%b required 0000/1", STATUS, wr_ready);
    end
    tick();
    wr_valid = 1'b0;
    vs = 1'b0;
    tick();
    bus_write(3'd7, 16'h0000);
    pulse_vs();
    n_cmp++;
    if (STATUS !== 16'hBEEF) begin
      n_err++; $display("FAIL held_write: STATUS=%h required beef", STATUS);
    end
    $display("held write STATUS=%h", STATUS);
  endtask

  task automatic test_stale();
    logic [3:0] exp_stale;
    exp_stale = 4'b1100;
    bus_write(3'd4, 16'h0077);
    for (int i = 0; i < 4; i++) begin
      pulse_vs();
      n_cmp++;
      if (stale !== exp_stale[i]) begin
        n_err++; $display("FAIL stale_count[%0d]: stale=%b required %b", i, stale, exp_stale[i]);
      end
      $display("frame %0d stale=%b", i + 1, stale);
    end
    n_cmp++;
    if (P_SOURCED !== 8'h00) begin
      n_err++; $display("FAIL vs_in_fill: P_SOURCED=%h required 00", P_SOURCED);
    end
    bus_write(3'd7, 16'h0000);
    pulse_vs();
    n_cmp++;
    if (stale !== 1'b0 || P_SOURCED !== 8'h77) begin
      n_err++; $display("FAIL stale_clear: stale=%b P_SOURCED=%h required 0/77", stale, P_SOURCED);
    end
  endtask

  task automatic test_reset_in_pend();
    bus_write(3'd3, 16'h0055);
    bus_write(3'd7, 16'h0000);
    n_cmp++;
    if (pending !== 1'b1) begin
      n_err++; $display("FAIL pend_before_reset: pending=%b required 1", pending);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_cmp++;
    if ({STATUS, FORCED, CHARGE, DISCHARGE, P_SOURCED, P_SINKED, BATTERY} !== 72'h0 ||
        {wr_ready, pending, stale} !== 3'b100) begin
      n_err++; $display("FAIL reset_in_pend: outs=%h flags=%b required 0/100",
                        {STATUS, FORCED, CHARGE, DISCHARGE, P_SOURCED, P_SINKED, BATTERY},
                        {wr_ready, pending, stale});
    end
    bus_write(3'd7, 16'h0000);
    pulse_vs();
    n_cmp++;
    if (DISCHARGE !== 8'h00 || STATUS !== 16'h0000) begin
      n_err++; $display("FAIL shadow_discarded: DISCHARGE=%h STATUS=%h required 00/0000", DISCHARGE, STATUS);
    end
    $display("reset in pend checked");
  endtask

  initial begin
    test_reset();
    test_commit();
    test_battery();
    test_commit_with_vs();
    test_back_to_back();
    test_stale();
    test_reset_in_pend();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
